dcache_wb_buffer: RTL and testbench

//  Write-back buffer between dcache (upstream) and the cacheline adapter's dcache port (downstream).

---
 rtl/dcache_wb_buffer_pkg.sv | 28 ++
 rtl/dcache_wb_buffer_if.sv | 16 +
 rtl/dcache_wb_buffer_addr_match.sv | 27 ++
 rtl/dcache_wb_buffer.sv | 148 ++++++++++++++
 tb/tb_dcache_wb_buffer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_wb_buffer_pkg.sv
// Shared types for the dcache write-back buffer: FSM states, buffer entries,
// and line-address helpers.
package dcache_wb_buffer_pkg;

  localparam int LINE_W = 256;
  localparam int OFS_W  = 5;
  localparam int TAG_W  = 32 - OFS_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RESP
  } wbb_state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } wbb_entry_t;

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag);
    return {tag, {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_wb_buffer_if.sv
// Line-granular memory port (request/response) used on both the dcache side
// and the adapter side of the write-back buffer.
interface dcache_wb_buffer_if;
  import dcache_wb_buffer_pkg::*;

  logic [31:0]       addr;
  logic              read;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output addr, read, write, wdata, input rdata, resp);
  modport slave  (input addr, read, write, wdata, output rdata, resp);

endinterface

// File: rtl/dcache_wb_buffer_addr_match.sv
// Combinational CAM: finds the valid entry whose line tag equals the lookup tag.
// Entries never share a tag, so at most one bit can match.
module dcache_wb_buffer_addr_match
  import dcache_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = 1
) (
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH-1:0][TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0]            lookup_i,
  output logic                        hit_o,
  output logic [IDX_W-1:0]            idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (tag_i[i] == lookup_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer FSM. state | meaning:
// IDLE sample ufp | RD_ISSUE/RD_WAIT fetch miss | WR_ISSUE/WR_WAIT drain head | RESP ufp completion
module dcache_wb_buffer
  import dcache_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  dcache_wb_buffer_if.slave  ufp,
  dcache_wb_buffer_if.master dfp
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wbb_state_t        state_q;
  wbb_entry_t        entries_q [DEPTH];
  logic [IDX_W-1:0]  head_q;
  logic [IDX_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] dfp_wdata_q;
  logic [31:0]       dfp_addr_q;
  logic              resp_q;
  logic              dfp_read_q;
  logic              dfp_write_q;

  logic [DEPTH-1:0]            valid_vec;
  logic [DEPTH-1:0][TAG_W-1:0] tag_vec;
  logic [TAG_W-1:0]            ufp_tag;
  logic                        hit;
  logic [IDX_W-1:0]            hit_idx;
  logic                        full;
  logic                        empty;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ufp_tag = ufp.addr[31:OFS_W];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

  always_comb begin
    valid_vec = '0;
    tag_vec   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      tag_vec[i]   = entries_q[i].tag;
    end
  end

  dcache_wb_buffer_addr_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_wbb_addr_match (
    .valid_i  (valid_vec),
    .tag_i    (tag_vec),
    .lookup_i (ufp_tag),
    .hit_o    (hit),
    .idx_o    (hit_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      dfp_wdata_q <= '0;
      dfp_addr_q  <= '0;
      resp_q      <= 1'b0;
      dfp_read_q  <= 1'b0;
      dfp_write_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ufp.read && hit) begin
            rdata_q <= entries_q[hit_idx].data;
            resp_q  <= 1'b1;
            state_q <= S_RESP;
          end else if (ufp.read) begin
            dfp_addr_q <= line_addr(ufp_tag);
            dfp_read_q <= 1'b1;
            state_q    <= S_RD_ISSUE;
          end else if (ufp.write && hit) begin
            entries_q[hit_idx].data <= ufp.wdata;
            rdata_q <= '0;
            resp_q  <= 1'b1;
            state_q <= S_RESP;
          end else if (ufp.write && !full) begin
            entries_q[tail_q] <= '{valid: 1'b1, tag: ufp_tag, data: ufp.wdata};
            tail_q  <= next_ptr(tail_q);
            count_q <= count_q + 1'b1;
            rdata_q <= '0;
            resp_q  <= 1'b1;
            state_q <= S_RESP;
          end else if (ufp.write || !empty) begin
            // A stalled full write is simply re-sampled once the head has drained.
            dfp_addr_q  <= line_addr(entries_q[head_q].tag);
            dfp_wdata_q <= entries_q[head_q].data;
            dfp_write_q <= 1'b1;
            state_q     <= S_WR_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          dfp_read_q <= 1'b0;
          state_q    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (dfp.resp) begin
            rdata_q <= dfp.rdata;
            resp_q  <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_WR_ISSUE: begin
          dfp_write_q <= 1'b0;
          state_q     <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (dfp.resp) begin
            entries_q[head_q].valid <= 1'b0;
            head_q  <= next_ptr(head_q);
            count_q <= count_q - 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_RESP: begin
          resp_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ufp.rdata = rdata_q;
  assign ufp.resp  = resp_q;
  assign dfp.addr  = dfp_addr_q;
  assign dfp.read  = dfp_read_q;
  assign dfp.write = dfp_write_q;
  assign dfp.wdata = dfp_wdata_q;

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer: vector table of ufp requests against a
// small adapter model, plus dfp transaction-order log and a reset-abort sequence.
module tb_dcache_wb_buffer;
  import dcache_wb_buffer_pkg::*;

  localparam int OP_IDLE = 0;
  localparam int OP_WR   = 1;
  localparam int OP_RD   = 2;
  localparam int ADP_LAT = 2;
  localparam int NVEC    = 17;

  localparam logic [255:0] D1 = {8{32'h1111_1111}};
  localparam logic [255:0] D2 = {8{32'h2222_2222}};
  localparam logic [255:0] D3 = {8{32'h3333_3333}};
  localparam logic [255:0] DA = {8{32'haaaa_aaaa}};
  localparam logic [255:0] DB = {8{32'hbbbb_bbbb}};
  localparam logic [255:0] DC = {8{32'hcccc_cccc}};
  localparam logic [255:0] DD = {8{32'hdddd_dddd}};
  localparam logic [255:0] DE = {8{32'heeee_eeee}};
  localparam logic [255:0] DG = {8{32'h6666_6666}};
  localparam logic [255:0] P800 = {8{32'h0000_0800}};
  localparam logic [255:0] P600 = {8{32'h0000_0600}};
  localparam logic [255:0] ZERO = 256'h0;

  typedef struct {
    int           op;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_rdata;
    int           exp_lat;   // idle cycles for OP_IDLE
  } vec_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } dfp_ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dcache_wb_buffer_if u_ufp ();
  dcache_wb_buffer_if u_dfp ();

  dcache_wb_buffer #(.DEPTH(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .ufp (u_ufp),
    .dfp (u_dfp)
  );

  int checks = 0;
  int errors = 0;
  vec_t    vecs [NVEC];
  dfp_ev_t log_q [$];
  dfp_ev_t exp_log [$];
  logic [255:0] mem [logic [26:0]];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Adapter model: logs each dfp request and answers ADP_LAT cycles later.
  initial begin
    dfp_ev_t      ev;
    logic [255:0] line;
    u_dfp.resp  = 1'b0;
    u_dfp.rdata = '0;
    forever begin
      @(negedge clk);
      if (u_dfp.read || u_dfp.write) begin
        ev.wr   = u_dfp.write;
        ev.addr = u_dfp.addr;
        ev.data = u_dfp.write ? u_dfp.wdata : ZERO;
        log_q.push_back(ev);
        if (ev.wr) mem[ev.addr[31:5]] = ev.data;
        line = mem.exists(ev.addr[31:5]) ? mem[ev.addr[31:5]] : {8{ev.addr}};
        repeat (ADP_LAT) @(negedge clk);
        u_dfp.resp  = 1'b1;
        u_dfp.rdata = ev.wr ? ZERO : line;
        @(negedge clk);
        u_dfp.resp  = 1'b0;
        u_dfp.rdata = '0;
      end
    end
  end

  // Pulse-shape rules on both ports.
  bit prev_rd, prev_wr, prev_resp;
  always @(negedge clk) begin
    if (u_dfp.read || u_dfp.write) begin
      check("dfp read/write exclusive", 256'(u_dfp.read & u_dfp.write), ZERO);
      check("dfp pulse width", 256'((u_dfp.read & prev_rd) | (u_dfp.write & prev_wr)), ZERO);
    end
    if (u_ufp.resp) check("ufp_resp pulse width", 256'(prev_resp), ZERO);
    prev_rd   = u_dfp.read;
    prev_wr   = u_dfp.write;
    prev_resp = u_ufp.resp;
  end

  task automatic do_req(input int op, input logic [31:0] addr, input logic [255:0] wd,
                        input logic [255:0] exp_rd, input int exp_lat, input string name);
    int lat = 0;
    bit got = 0;
    logic [255:0] rd = '0;
    u_ufp.addr  = addr;
    u_ufp.wdata = wd;
    u_ufp.read  = (op == OP_RD);
    u_ufp.write = (op == OP_WR);
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (u_ufp.resp) begin
        got = 1;
        rd  = u_ufp.rdata;
      end
    end
    u_ufp.read  = 1'b0;
    u_ufp.write = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no ufp_resp within %0d cycles", name, lat);
    end else begin
      check({name, " latency"}, 256'(lat), 256'(exp_lat));
      check({name, " rdata"}, rd, exp_rd);
    end
    @(negedge clk);  // S_RESP cycle
  endtask

  task automatic do_idle(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (u_ufp.resp) check({name, " spurious ufp_resp"}, 256'(u_ufp.resp), ZERO);
    end
  endtask

  task automatic add_exp(input bit wr, input logic [31:0] a, input logic [255:0] d);
    dfp_ev_t ev;
    ev.wr = wr; ev.addr = a; ev.data = d;
    exp_log.push_back(ev);
  endtask

  initial begin
    int log_n;
    u_ufp.read  = 1'b0;
    u_ufp.write = 1'b0;
    u_ufp.addr  = '0;
    u_ufp.wdata = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ufp_resp", 256'(u_ufp.resp), ZERO);
    check("reset ufp_rdata", u_ufp.rdata, ZERO);
    check("reset dfp_read", 256'(u_dfp.read), ZERO);
    check("reset dfp_write", 256'(u_dfp.write), ZERO);
    check("reset dfp_addr", 256'(u_dfp.addr), ZERO);
    check("reset dfp_wdata", u_dfp.wdata, ZERO);
    check("reset count", 256'(u_dut.count_q), ZERO);
    check("reset state", 256'(u_dut.state_q), 256'(S_IDLE));
    rst = 1'b1;
    @(negedge clk);

    vecs[0]  = '{OP_WR,   32'h0000_1000, D1, ZERO, 1};
    vecs[1]  = '{OP_IDLE, 32'h0,         ZERO, ZERO, 10};
    vecs[2]  = '{OP_WR,   32'h0000_2000, D2, ZERO, 1};
    vecs[3]  = '{OP_RD,   32'h0000_2000, ZERO, D2, 1};
    vecs[4]  = '{OP_IDLE, 32'h0,         ZERO, ZERO, 10};
    vecs[5]  = '{OP_WR,   32'h0000_0100, DA, ZERO, 1};
    vecs[6]  = '{OP_WR,   32'h0000_0200, DB, ZERO, 1};
    vecs[7]  = '{OP_WR,   32'h0000_0300, DC, ZERO, 5};
    vecs[8]  = '{OP_IDLE, 32'h0,         ZERO, ZERO, 20};
    vecs[9]  = '{OP_WR,   32'h0000_0400, DD, ZERO, 1};
    vecs[10] = '{OP_WR,   32'h0000_041C, D3, ZERO, 1};
    vecs[11] = '{OP_IDLE, 32'h0,         ZERO, ZERO, 10};
    vecs[12] = '{OP_WR,   32'h0000_0100, DE, ZERO, 1};
    vecs[13] = '{OP_RD,   32'h0000_0800, ZERO, P800, 4};
    vecs[14] = '{OP_IDLE, 32'h0,         ZERO, ZERO, 10};
    vecs[15] = '{OP_RD,   32'h0000_101F, ZERO, D1, 4};
    vecs[16] = '{OP_IDLE, 32'h0,         ZERO, ZERO, 5};

    add_exp(1, 32'h0000_1000, D1);
    add_exp(1, 32'h0000_2000, D2);
    add_exp(1, 32'h0000_0100, DA);
    add_exp(1, 32'h0000_0200, DB);
    add_exp(1, 32'h0000_0300, DC);
    add_exp(1, 32'h0000_0400, D3);
    add_exp(0, 32'h0000_0800, ZERO);
    add_exp(1, 32'h0000_0100, DE);
    add_exp(0, 32'h0000_1000, ZERO);
    add_exp(0, 32'h0000_0900, ZERO);
    add_exp(0, 32'h0000_0600, ZERO);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].op == OP_IDLE)
        do_idle(vecs[i].exp_lat, $sformatf("vec%0d", i));
      else
        do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
               vecs[i].exp_lat, $sformatf("vec%0d", i));
      if (i == 10) check("coalesce count", 256'(u_dut.count_q), 256'(1));
    end
    check("drained count", 256'(u_dut.count_q), ZERO);

    // Reset while a miss is outstanding: buffered 0x600 is lost, late dfp_resp ignored.
    do_req(OP_WR, 32'h0000_0600, DG, ZERO, 1, "rst buffered write");
    u_ufp.addr  = 32'h0000_0900;
    u_ufp.read  = 1'b1;
    @(negedge clk);
    check("rst miss dfp_read", 256'(u_dfp.read), 256'(1));
    @(negedge clk);
    check("rst in RD_WAIT", 256'(u_dut.state_q), 256'(S_RD_WAIT));
    rst = 1'b0;
    u_ufp.read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst abort state", 256'(u_dut.state_q), 256'(S_IDLE));
    check("rst abort count", 256'(u_dut.count_q), ZERO);
    check("rst abort ufp_resp", 256'(u_ufp.resp), ZERO);
    check("rst abort dfp_read", 256'(u_dfp.read), ZERO);
    check("rst abort dfp_addr", 256'(u_dfp.addr), ZERO);
    check("rst abort rdata", u_ufp.rdata, ZERO);
    log_n = log_q.size();
    do_idle(10, "post-reset idle");
    check("post-reset no dfp traffic", 256'(log_q.size()), 256'(log_n));
    check("post-reset state", 256'(u_dut.state_q), 256'(S_IDLE));
    do_req(OP_RD, 32'h0000_0600, ZERO, P600, 4, "post-reset lost line");
    do_idle(5, "tail idle");

    check("dfp log length", 256'(log_q.size()), 256'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < log_q.size(); i++) begin
      check($sformatf("dfp[%0d] kind", i), 256'(log_q[i].wr), 256'(exp_log[i].wr));
      check($sformatf("dfp[%0d] addr", i), 256'(log_q[i].addr), 256'(exp_log[i].addr));
      if (exp_log[i].wr) check($sformatf("dfp[%0d] wdata", i), log_q[i].data, exp_log[i].data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
